// File: rtl/calc_req_arbiter.sv
// Round-robin arbiter sharing one fullcalc among N_REQ requesters: pick, latch operands,
// pulse GO, wait for a qualified done (or watchdog expiry), then return the result with ack.
module calc_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 4,
    parameter int OPW     = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*OPW-1:0]     req_op,
    input  logic [N_REQ*DW-1:0]      req_a,
    input  logic [N_REQ*DW-1:0]      req_b,
    output logic [N_REQ-1:0]         ack,
    output logic [DW-1:0]            res_hi,
    output logic [DW-1:0]            res_lo,
    output logic                     res_err,
    output logic                     res_tmo,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic                     res_valid,
    output logic                     busy,
    output logic                     calc_go,
    output logic [OPW-1:0]           calc_op,
    output logic [DW-1:0]            calc_in1,
    output logic [DW-1:0]            calc_in2,
    input  logic                     calc_done,
    input  logic                     calc_error,
    input  logic [DW-1:0]            calc_hi,
    input  logic [DW-1:0]            calc_lo
);

    localparam int IDW = $clog2(N_REQ);
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q,   state_d;
    logic [IDW-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [IDW-1:0]   grant_q,   grant_d;
    logic [OPW-1:0]   op_q,      op_d;
    logic [DW-1:0]    in1_q,     in1_d;
    logic [DW-1:0]    in2_q,     in2_d;
    logic             armed_q,   armed_d;
    logic [WDW-1:0]   wd_q,      wd_d;
    logic [DW-1:0]    res_hi_q,  res_hi_d;
    logic [DW-1:0]    res_lo_q,  res_lo_d;
    logic             res_err_q, res_err_d;
    logic             res_tmo_q, res_tmo_d;
    logic [IDW-1:0]   res_id_q,  res_id_d;

    logic             pick_vld;
    logic [IDW-1:0]   pick_id;
    logic [IDW:0]     rr_sum;
    logic [OPW-1:0]   sel_op;
    logic [DW-1:0]    sel_a;
    logic [DW-1:0]    sel_b;

    // Walk from the farthest candidate back to rr_ptr so the nearest requester wins last.
    always_comb begin : rr_pick
        pick_vld = 1'b0;
        pick_id  = '0;
        rr_sum   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (rr_sum >= (IDW+1)'(N_REQ)) begin
                rr_sum = rr_sum - (IDW+1)'(N_REQ);
            end
            if (req[rr_sum[IDW-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = rr_sum[IDW-1:0];
            end
        end
    end

    always_comb begin : operand_mux
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_id == IDW'(i)) begin
                sel_op = req_op[i*OPW +: OPW];
                sel_a  = req_a[i*DW +: DW];
                sel_b  = req_b[i*DW +: DW];
            end
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        op_d      = op_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        armed_d   = armed_q;
        wd_d      = wd_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        res_err_d = res_err_q;
        res_tmo_d = res_tmo_q;
        res_id_d  = res_id_q;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_id;
                    op_d    = sel_op;
                    in1_d   = sel_a;
                    in2_d   = sel_b;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                armed_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done that is already high at GO belongs to the previous op;
                // only a done seen after at least one low sample is accepted.
                if (!calc_done) begin
                    armed_d = 1'b1;
                end
                if (armed_q && calc_done) begin
                    res_hi_d  = calc_hi;
                    res_lo_d  = calc_lo;
                    res_err_d = calc_error;
                    res_tmo_d = 1'b0;
                    res_id_d  = grant_q;
                    state_d   = S_RESP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    res_hi_d  = '0;
                    res_lo_d  = '0;
                    res_err_d = 1'b1;
                    res_tmo_d = 1'b1;
                    res_id_d  = grant_q;
                    state_d   = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP: begin
                rr_ptr_d = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            op_q      <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            armed_q   <= 1'b0;
            wd_q      <= '0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            res_err_q <= 1'b0;
            res_tmo_q <= 1'b0;
            res_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            op_q      <= op_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            armed_q   <= armed_d;
            wd_q      <= wd_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
            res_err_q <= res_err_d;
            res_tmo_q <= res_tmo_d;
            res_id_q  <= res_id_d;
        end
    end

    always_comb begin : outputs
        ack = '0;
        if (state_q == S_RESP) begin
            ack[grant_q] = 1'b1;
        end
    end

    assign res_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign calc_go   = (state_q == S_ISSUE);
    assign calc_op   = op_q;
    assign calc_in1  = in1_q;
    assign calc_in2  = in2_q;
    assign res_hi    = res_hi_q;
    assign res_lo    = res_lo_q;
    assign res_err   = res_err_q;
    assign res_tmo   = res_tmo_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_calc_req_arbiter.sv
// Directed bench for calc_req_arbiter with a small behavioural fullcalc responder
// (configurable done latency, stale done, never-done and divide-by-zero error).
module tb_calc_req_arbiter;

    localparam int N_REQ   = 4;
    localparam int DW      = 4;
    localparam int OPW     = 3;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_REQ-1:0]     req;
    logic [N_REQ*OPW-1:0] req_op;
    logic [N_REQ*DW-1:0]  req_a;
    logic [N_REQ*DW-1:0]  req_b;
    logic [N_REQ-1:0]     ack;
    logic [DW-1:0]        res_hi;
    logic [DW-1:0]        res_lo;
    logic                 res_err;
    logic                 res_tmo;
    logic [IDW-1:0]       res_id;
    logic                 res_valid;
    logic                 busy;
    logic                 calc_go;
    logic [OPW-1:0]       calc_op;
    logic [DW-1:0]        calc_in1;
    logic [DW-1:0]        calc_in2;
    logic                 calc_done;
    logic                 calc_error;
    logic [DW-1:0]        calc_hi;
    logic [DW-1:0]        calc_lo;

    int n_cmp  = 0;
    int n_fail = 0;
    int go_cnt = 0;

    int             m_cnt;
    int             m_delay = 3;
    bit             m_stale = 1'b0;
    bit             m_never = 1'b0;
    logic [OPW-1:0] m_op;
    logic [DW-1:0]  m_a;
    logic [DW-1:0]  m_b;

    calc_req_arbiter #(
        .N_REQ(N_REQ), .DW(DW), .OPW(OPW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .ack(ack), .res_hi(res_hi), .res_lo(res_lo), .res_err(res_err), .res_tmo(res_tmo),
        .res_id(res_id), .res_valid(res_valid), .busy(busy), .calc_go(calc_go),
        .calc_op(calc_op), .calc_in1(calc_in1), .calc_in2(calc_in2), .calc_done(calc_done),
        .calc_error(calc_error), .calc_hi(calc_hi), .calc_lo(calc_lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && calc_go) go_cnt++;
    end

    // Opcode 0 = ADD (carry into HI), opcode 3 = DIV (HI = remainder, LO = quotient).
    function automatic logic [2*DW:0] model_calc(input logic [OPW-1:0] op,
                                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] s;
        s = {{DW{1'b0}}, a} + {{DW{1'b0}}, b};
        model_calc = '0;
        case (op)
            3'd0: model_calc = {1'b0, s};
            3'd3: begin
                if (b == '0) model_calc = {1'b1, {(2*DW){1'b0}}};
                else         model_calc = {1'b0, a % b, a / b};
            end
            default: model_calc = '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt      <= 0;
            calc_done  <= 1'b0;
            calc_error <= 1'b0;
            calc_hi    <= '0;
            calc_lo    <= '0;
        end else if (calc_go) begin
            m_cnt <= 1;
            m_op  <= calc_op;
            m_a   <= calc_in1;
            m_b   <= calc_in2;
            if (!m_stale) calc_done <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt + 1;
            if (m_stale && m_cnt == 1) calc_done <= 1'b0;
            if (!m_never && m_cnt == m_delay - 1) begin
                calc_done <= 1'b1;
                {calc_error, calc_hi, calc_lo} <= model_calc(m_op, m_a, m_b);
                m_cnt <= 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic [OPW-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_op[id*OPW +: OPW] = op;
        req_a[id*DW +: DW]    = a;
        req_b[id*DW +: DW]    = b;
    endtask

    task automatic wait_ack(input int max_cyc, output int n);
        n = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if (ack !== '0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0; req_op = '0; req_a = '0; req_b = '0;
        repeat (3) tick();
        n_cmp++;
        if ({busy, ack, res_valid, calc_go} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/ack/valid/go=%b expected 0000000", {busy, ack, res_valid, calc_go});
        end
        n_cmp++;
        if ({calc_op, calc_in1, calc_in2} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_calc_bus: got %h expected 0", {calc_op, calc_in1, calc_in2});
        end
        n_cmp++;
        if ({res_hi, res_lo, res_err, res_tmo, res_id} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_res: got %h expected 0", {res_hi, res_lo, res_err, res_tmo, res_id});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        int g0;
        m_delay = 3; m_stale = 1'b0; m_never = 1'b0;
        drive(0, 3'd0, 4'd3, 4'd4);
        g0  = go_cnt;
        req = 4'b0001;
        tick();
        n_cmp++;
        if ({calc_go, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL single_go: go/busy=%b expected 11", {calc_go, busy});
        end
        n_cmp++;
        if ({calc_op, calc_in1, calc_in2} !== {3'd0, 4'd3, 4'd4}) begin
            n_fail++;
            $display("FAIL single_operands: got %h expected %h", {calc_op, calc_in1, calc_in2}, {3'd0, 4'd3, 4'd4});
        end
        wait_ack(20, n);
        n_cmp++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL single_latency: ack after %0d cycles expected 4", n);
        end
        n_cmp++;
        if ({ack, res_valid, res_id} !== {4'b0001, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL single_ack: ack/valid/id=%b expected 0001100", {ack, res_valid, res_id});
        end
        n_cmp++;
        if ({res_hi, res_lo, res_err, res_tmo} !== {4'd0, 4'd7, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_result: hi/lo/err/tmo=%h expected %h", {res_hi, res_lo, res_err, res_tmo}, {4'd0, 4'd7, 2'b00});
        end
        req = '0;
        tick();
        n_cmp++;
        if ({ack, res_valid, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL single_after: ack/valid/busy=%b expected 000000", {ack, res_valid, busy});
        end
        n_cmp++;
        if (go_cnt - g0 != 1) begin
            n_fail++;
            $display("FAIL single_go_count: got %0d expected 1", go_cnt - g0);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int n;
        int id;
        logic [N_REQ-1:0] exp_ack;
        logic [DW-1:0]    exp_lo [N_REQ] = '{4'd1, 4'd4, 4'd7, 4'd10};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) drive(i, 3'd0, 4'(i + 1), 4'(2 * i));
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            id = s % N_REQ;
            exp_ack = '0;
            exp_ack[id] = 1'b1;
            wait_ack(20, n);
            n_cmp++;
            if (n == 0 || ack !== exp_ack || res_id !== IDW'(id)) begin
                n_fail++;
                $display("FAIL rr_order_%0d: ack=%b id=%0d after %0d cycles expected ack=%b id=%0d", s, ack, res_id, n, exp_ack, id);
            end
            n_cmp++;
            if (res_lo !== exp_lo[id] || res_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_result_%0d: lo=%0d valid=%b expected lo=%0d valid=1", s, res_lo, res_valid, exp_lo[id]);
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_stale_done();
        int n;
        m_stale = 1'b1; m_delay = 4;
        drive(1, 3'd0, 4'd5, 4'd6);
        req = 4'b0010;
        tick();
        wait_ack(20, n);
        n_cmp++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL stale_latency: ack after %0d cycles expected 5", n);
        end
        n_cmp++;
        if ({ack, res_id, res_hi, res_lo} !== {4'b0010, 2'd1, 4'd0, 4'd11}) begin
            n_fail++;
            $display("FAIL stale_result: ack=%b id=%0d hi=%0d lo=%0d expected ack=0010 id=1 hi=0 lo=11", ack, res_id, res_hi, res_lo);
        end
        req = '0;
        tick();
        m_stale = 1'b0; m_delay = 3;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        m_never = 1'b1;
        drive(2, 3'd0, 4'd1, 4'd1);
        req = 4'b0100;
        tick();
        wait_ack(TIMEOUT + 10, n);
        n_cmp++;
        if (n != TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL tmo_latency: ack after %0d cycles expected %0d", n, TIMEOUT + 1);
        end
        n_cmp++;
        if ({ack, res_id, res_tmo, res_err} !== {4'b0100, 2'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL tmo_flags: ack=%b id=%0d tmo=%b err=%b expected ack=0100 id=2 tmo=1 err=1", ack, res_id, res_tmo, res_err);
        end
        n_cmp++;
        if ({res_hi, res_lo} !== 8'h00) begin
            n_fail++;
            $display("FAIL tmo_data: hi/lo=%h expected 00", {res_hi, res_lo});
        end
        req = '0;
        tick();
        m_never = 1'b0;
        tick();
    endtask

    task automatic test_error();
        int n;
        int g0;
        g0 = go_cnt;
        drive(3, 3'd3, 4'd9, 4'd0);
        req = 4'b1000;
        tick();
        wait_ack(20, n);
        n_cmp++;
        if (n != 4 || ack !== 4'b1000 || res_id !== 2'd3) begin
            n_fail++;
            $display("FAIL err_ack: ack=%b id=%0d after %0d cycles expected ack=1000 id=3 after 4", ack, res_id, n);
        end
        n_cmp++;
        if ({res_err, res_tmo} !== 2'b10) begin
            n_fail++;
            $display("FAIL err_flags: err/tmo=%b expected 10", {res_err, res_tmo});
        end
        req = '0;
        tick();
        n_cmp++;
        if ({ack, res_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL err_single_pulse: ack/valid=%b expected 00000", {ack, res_valid});
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || ack !== 4'b0 || go_cnt - g0 != 1) begin
            n_fail++;
            $display("FAIL err_after: busy=%b ack=%b go_count=%0d expected busy=0 ack=0000 go_count=1", busy, ack, go_cnt - g0);
        end
    endtask

    task automatic test_rst_wait();
        int n;
        drive(2, 3'd0, 4'd1, 4'd2);
        req = 4'b0100;
        wait_ack(20, n);
        n_cmp++;
        if (n == 0 || ack !== 4'b0100 || res_lo !== 4'd3) begin
            n_fail++;
            $display("FAIL rstw_pre: ack=%b lo=%0d after %0d cycles expected ack=0100 lo=3", ack, res_lo, n);
        end
        req = '0;
        tick();
        req = 4'b0100;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b1 || calc_in2 !== 4'd2) begin
            n_fail++;
            $display("FAIL rstw_inflight: busy=%b in2=%0d expected busy=1 in2=2", busy, calc_in2);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({busy, ack, res_valid, calc_go} !== 7'b0) begin
            n_fail++;
            $display("FAIL rstw_ctrl: busy/ack/valid/go=%b expected 0000000", {busy, ack, res_valid, calc_go});
        end
        n_cmp++;
        if ({calc_op, calc_in1, calc_in2, res_lo, res_id} !== 17'b0) begin
            n_fail++;
            $display("FAIL rstw_data: got %h expected 0", {calc_op, calc_in1, calc_in2, res_lo, res_id});
        end
        rst = 1'b0;
        drive(1, 3'd0, 4'd4, 4'd4);
        drive(3, 3'd0, 4'd7, 4'd7);
        req = 4'b1010;
        wait_ack(20, n);
        n_cmp++;
        if (n == 0 || ack !== 4'b0010 || res_id !== 2'd1 || res_lo !== 4'd8) begin
            n_fail++;
            $display("FAIL rstw_new_req: ack=%b id=%0d lo=%0d after %0d cycles expected ack=0010 id=1 lo=8", ack, res_id, res_lo, n);
        end
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stale_done();
        test_timeout();
        test_error();
        test_rst_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "time limit");
    end

endmodule
